// File: rtl/ahb_master_arbiter.sv
// Ownership arbiter for a four-port AHB master mux: round-robin with a beat quantum,
// switching only at lock-free, burst-free points once the mux has adopted the last select.
module ahb_master_arbiter #(
  parameter logic [3:0] M_ENABLE    = 4'b1111,
  parameter logic [1:0] PARK_MASTER = 2'd0,
  parameter int         QUANTUM     = 16
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic [3:0] M_REQ,
  input  logic [3:0] M_LOCK,
  input  logic [1:0] MOUT_HTRANS,
  input  logic       MOUT_HREADY,
  output logic [1:0] HMSEL,
  output logic [3:0] HGRANT,
  output logic [1:0] ARB_STATE
);

  typedef enum logic [1:0] {
    ST_PARK    = 2'd0,
    ST_HANDOFF = 2'd1,
    ST_OWNED   = 2'd2
  } arb_state_t;

  localparam logic [7:0] QUANTUM_C = QUANTUM[7:0];
  localparam logic [1:0] HT_BUSY   = 2'd1;
  localparam logic [1:0] HT_SEQ    = 2'd3;

  arb_state_t state_r, state_s;
  logic [1:0] hmsel_r, hmsel_s;
  logic [3:0] hgrant_r;
  logic [7:0] beat_cnt_r, beat_cnt_s;
  logic [1:0] rr_ptr_r, rr_ptr_s;

  logic [3:0] req_v_s;
  logic [3:0] other_v_s;
  logic [3:0] pick_vec_s;
  logic [1:0] winner_s;
  logic       beat_s;
  logic       own_req_s;
  logic       own_lock_s;
  logic       yield_ok_s;

  function automatic logic [3:0] onehot(input logic [1:0] sel);
    onehot = 4'b0001 << sel;
  endfunction

  // Circular search starting one past ptr, so ptr itself is considered last.
  function automatic logic [1:0] rr_pick(input logic [3:0] vec, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && vec[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // Request qualification, beat detection and winner selection.
  always_comb begin
    req_v_s    = M_REQ & M_ENABLE;
    other_v_s  = req_v_s & ~hgrant_r;
    beat_s     = MOUT_HREADY && MOUT_HTRANS[1];
    own_req_s  = M_REQ[hmsel_r];
    own_lock_s = M_LOCK[hmsel_r];
    if (state_r == ST_OWNED) begin
      pick_vec_s = other_v_s;
    end else begin
      pick_vec_s = req_v_s;
    end
    winner_s   = rr_pick(pick_vec_s, rr_ptr_r);
    // A locked owner only loses the bus once it stops requesting.
    yield_ok_s = (!own_lock_s || !own_req_s) &&
                 (MOUT_HTRANS != HT_SEQ) && (MOUT_HTRANS != HT_BUSY) &&
                 (!own_req_s || ((beat_cnt_r >= QUANTUM_C) && (other_v_s != 4'b0000)));
  end

  // Next-state logic; every decision is gated by MOUT_HREADY so wait states freeze all state.
  always_comb begin
    state_s    = state_r;
    hmsel_s    = hmsel_r;
    beat_cnt_s = beat_cnt_r;
    rr_ptr_s   = rr_ptr_r;
    case (state_r)
      ST_PARK: begin
        if ((req_v_s != 4'b0000) && MOUT_HREADY) begin
          if (winner_s == hmsel_r) begin
            state_s    = ST_OWNED;
            beat_cnt_s = 8'd0;
            rr_ptr_s   = winner_s;
          end else begin
            hmsel_s = winner_s;
            state_s = ST_HANDOFF;
          end
        end else begin
          state_s = ST_PARK;
        end
      end
      ST_HANDOFF: begin
        // The mux latches HMSEL on the first ready cycle; that completes the handoff.
        if (MOUT_HREADY) begin
          beat_cnt_s = 8'd0;
          rr_ptr_s   = hmsel_r;
          if ((req_v_s == 4'b0000) && (hmsel_r == PARK_MASTER)) begin
            state_s = ST_PARK;
          end else begin
            state_s = ST_OWNED;
          end
        end else begin
          state_s = ST_HANDOFF;
        end
      end
      ST_OWNED: begin
        if (MOUT_HREADY) begin
          if (beat_s && (beat_cnt_r < QUANTUM_C)) begin
            beat_cnt_s = beat_cnt_r + 8'd1;
          end else begin
            beat_cnt_s = beat_cnt_r;
          end
          if (yield_ok_s) begin
            if (other_v_s != 4'b0000) begin
              hmsel_s = winner_s;
              state_s = ST_HANDOFF;
            end else begin
              hmsel_s = PARK_MASTER;
              if (hmsel_r == PARK_MASTER) begin
                state_s = ST_PARK;
              end else begin
                state_s = ST_HANDOFF;
              end
            end
          end else begin
            state_s = ST_OWNED;
          end
        end else begin
          state_s = ST_OWNED;
        end
      end
      default: begin
        state_s    = ST_PARK;
        hmsel_s    = PARK_MASTER;
        beat_cnt_s = 8'd0;
        rr_ptr_s   = PARK_MASTER;
      end
    endcase
  end

  // State and registered outputs; HGRANT is recomputed from the same next select as HMSEL.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r    <= ST_PARK;
      hmsel_r    <= PARK_MASTER;
      hgrant_r   <= onehot(PARK_MASTER);
      beat_cnt_r <= 8'd0;
      rr_ptr_r   <= PARK_MASTER;
    end else begin
      state_r    <= state_s;
      hmsel_r    <= hmsel_s;
      hgrant_r   <= onehot(hmsel_s);
      beat_cnt_r <= beat_cnt_s;
      rr_ptr_r   <= rr_ptr_s;
    end
  end

  assign HMSEL     = hmsel_r;
  assign HGRANT    = hgrant_r;
  assign ARB_STATE = state_r;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: a per-cycle vector table plus hand-written
// sequences for wait states during handoff, reset while owned and a disabled requester.
module tb_ahb_master_arbiter;

  localparam logic [1:0] I = 2'd0;
  localparam logic [1:0] N = 2'd2;
  localparam logic [1:0] S = 2'd3;
  localparam logic [1:0] P = 2'd0;
  localparam logic [1:0] H = 2'd1;
  localparam logic [1:0] O = 2'd2;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] M_REQ, M_LOCK, m_req2;
  logic [1:0] MOUT_HTRANS;
  logic       MOUT_HREADY;
  logic [1:0] hmsel, hmsel2, arb_state, arb_state2;
  logic [3:0] hgrant, hgrant2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] htrans;
    logic       hready;
    logic [1:0] sel;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  always #5 HCLK = ~HCLK;

  ahb_master_arbiter #(.M_ENABLE(4'b1111), .PARK_MASTER(2'd0), .QUANTUM(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .M_REQ(M_REQ), .M_LOCK(M_LOCK),
    .MOUT_HTRANS(MOUT_HTRANS), .MOUT_HREADY(MOUT_HREADY),
    .HMSEL(hmsel), .HGRANT(hgrant), .ARB_STATE(arb_state)
  );

  ahb_master_arbiter #(.M_ENABLE(4'b1011), .PARK_MASTER(2'd0), .QUANTUM(16)) dut_en (
    .HCLK(HCLK), .HRESET(HRESET), .M_REQ(m_req2), .M_LOCK(4'b0000),
    .MOUT_HTRANS(MOUT_HTRANS), .MOUT_HREADY(MOUT_HREADY),
    .HMSEL(hmsel2), .HGRANT(hgrant2), .ARB_STATE(arb_state2)
  );

  function automatic void add(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                              input logic [1:0] htrans, input logic hready,
                              input logic [1:0] sel, input logic [1:0] st);
    vec_t v;
    v.rst = rst; v.req = req; v.lock = lock; v.htrans = htrans;
    v.hready = hready; v.sel = sel; v.st = st;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic [1:0] sel, input logic [1:0] st);
    logic [3:0] g;
    g = 4'b0001 << sel;
    chk({tag, ".hmsel"}, int'(hmsel), int'(sel));
    chk({tag, ".hgrant"}, int'(hgrant), int'(g));
    chk({tag, ".state"}, int'(arb_state), int'(st));
  endtask

  task automatic chk_en(input string tag);
    chk({tag, ".en_hmsel"}, int'(hmsel2), 0);
    chk({tag, ".en_hgrant"}, int'(hgrant2), 1);
    chk({tag, ".en_state"}, int'(arb_state2), 0);
  endtask

  initial begin
    HRESET = 1'b1; M_REQ = 4'b0000; M_LOCK = 4'b0000; m_req2 = 4'b0100;
    MOUT_HTRANS = I; MOUT_HREADY = 1'b1;

    // Reset, then a single request into an idle bus and the return to park.
    add(1'b1, 4'b0000, 4'b0000, I, 1'b1, 2'd0, P);
    for (int k = 0; k < 4; k++) add(1'b0, 4'b0000, 4'b0000, I, 1'b1, 2'd0, P);
    add(1'b0, 4'b0100, 4'b0000, I, 1'b1, 2'd2, H);
    add(1'b0, 4'b0100, 4'b0000, I, 1'b1, 2'd2, O);
    add(1'b0, 4'b0100, 4'b0000, N, 1'b1, 2'd2, O);
    add(1'b0, 4'b0000, 4'b0000, I, 1'b1, 2'd0, H);
    add(1'b0, 4'b0000, 4'b0000, I, 1'b1, 2'd0, P);
    // Rotation 0 -> 1 -> 2 -> 3 -> 0 with a quantum of two beats.
    add(1'b0, 4'b0001, 4'b0000, I, 1'b1, 2'd0, O);
    add(1'b0, 4'b1111, 4'b0000, N, 1'b1, 2'd0, O);
    add(1'b0, 4'b1111, 4'b0000, N, 1'b1, 2'd0, O);
    for (int k = 1; k <= 4; k++) begin
      add(1'b0, 4'b1111, 4'b0000, N, 1'b1, 2'(k % 4), H);
      add(1'b0, 4'b1111, 4'b0000, N, 1'b1, 2'(k % 4), O);
      if (k < 4) begin
        add(1'b0, 4'b1111, 4'b0000, N, 1'b1, 2'(k % 4), O);
        add(1'b0, 4'b1111, 4'b0000, N, 1'b1, 2'(k % 4), O);
      end
    end
    add(1'b0, 4'b0000, 4'b0000, I, 1'b1, 2'd0, P);
    // Owner 1 runs an 8-beat burst; master 3 requests mid-burst.
    add(1'b0, 4'b0010, 4'b0000, I, 1'b1, 2'd1, H);
    add(1'b0, 4'b0010, 4'b0000, N, 1'b1, 2'd1, O);
    add(1'b0, 4'b0010, 4'b0000, N, 1'b1, 2'd1, O);
    for (int k = 0; k < 7; k++) add(1'b0, 4'b1010, 4'b0000, S, 1'b1, 2'd1, O);
    add(1'b0, 4'b1010, 4'b0000, I, 1'b1, 2'd3, H);
    add(1'b0, 4'b1010, 4'b0000, N, 1'b1, 2'd3, O);
    add(1'b0, 4'b0001, 4'b0000, I, 1'b1, 2'd0, H);
    add(1'b0, 4'b0001, 4'b0000, I, 1'b1, 2'd0, O);
    // Locked owner 0 keeps the bus past its quantum; a non-owner lock is ignored.
    add(1'b0, 4'b0001, 4'b0001, N, 1'b1, 2'd0, O);
    add(1'b0, 4'b0001, 4'b0001, N, 1'b1, 2'd0, O);
    add(1'b0, 4'b0101, 4'b0001, N, 1'b1, 2'd0, O);
    add(1'b0, 4'b0101, 4'b0001, N, 1'b1, 2'd0, O);
    add(1'b0, 4'b0101, 4'b0001, I, 1'b1, 2'd0, O);
    add(1'b0, 4'b0101, 4'b0000, I, 1'b1, 2'd2, H);
    add(1'b0, 4'b0100, 4'b0000, I, 1'b1, 2'd2, O);
    add(1'b0, 4'b0001, 4'b0001, I, 1'b1, 2'd0, H);
    add(1'b0, 4'b0001, 4'b0001, I, 1'b1, 2'd0, O);
    add(1'b0, 4'b0000, 4'b0000, I, 1'b1, 2'd0, P);

    for (int i = 0; i < vecs.size(); i++) begin
      HRESET = vecs[i].rst; M_REQ = vecs[i].req; M_LOCK = vecs[i].lock;
      MOUT_HTRANS = vecs[i].htrans; MOUT_HREADY = vecs[i].hready;
      step();
      chk_main($sformatf("row%0d", i), vecs[i].sel, vecs[i].st);
    end
    chk_en("table_end");

    // Wait states while in HANDOFF hold the select and the state.
    M_REQ = 4'b1000; MOUT_HTRANS = I; MOUT_HREADY = 1'b1;
    step();
    chk_main("ho_start", 2'd3, H);
    for (int k = 0; k < 5; k++) begin
      MOUT_HREADY = 1'b0; MOUT_HTRANS = N;
      step();
      chk_main($sformatf("ho_wait%0d", k), 2'd3, H);
    end
    MOUT_HREADY = 1'b1; MOUT_HTRANS = I;
    step();
    chk_main("ho_done", 2'd3, O);

    // Reset while owned by 3, even with the slave stalling.
    HRESET = 1'b1; MOUT_HREADY = 1'b0; MOUT_HTRANS = S;
    step();
    chk_main("rst_owned", 2'd0, P);
    HRESET = 1'b0; M_REQ = 4'b0000; MOUT_HREADY = 1'b1; MOUT_HTRANS = I;
    step();
    chk_main("rst_after", 2'd0, P);
    chk_en("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
